// File: rtl/pipe_ctrl_hazard.sv
// Pipeline control carrier: moves the decoded control bundle through ID/EX, EX/MEM and MEM/WB,
// and resolves load-use / jr stalls, wrong-path kills and operand forwarding selects.
module pipe_ctrl_hazard #(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ALUOP_W+10:0]  id_ctrl,
  input  logic [REG_W-1:0]     id_rs,
  input  logic [REG_W-1:0]     id_rt,
  input  logic [REG_W-1:0]     id_rd,
  input  logic                 ex_branch_taken,
  output logic                 stall_if,
  output logic                 flush_ifid,
  output logic [1:0]           id_fwd_rs,
  output logic [ALUOP_W+6:0]   ex_ctrl,
  output logic [REG_W-1:0]     ex_wreg,
  output logic [REG_W-1:0]     ex_rs,
  output logic [REG_W-1:0]     ex_rt,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic                 mem_regwr,
  output logic                 mem_memrd,
  output logic                 mem_memwr,
  output logic [1:0]           mem_memtoreg,
  output logic [REG_W-1:0]     mem_wreg,
  output logic                 wb_regwr,
  output logic [1:0]           wb_memtoreg,
  output logic [REG_W-1:0]     wb_wreg
);

  localparam int A = ALUOP_W;

  logic [1:0]       id_pcsrc_s;
  logic [1:0]       id_regdst_s;
  logic [REG_W-1:0] id_wreg_s;
  logic             load_use_s;
  logic             jr_haz_s;
  logic             ex_bubble_s;

  assign id_pcsrc_s  = id_ctrl[A+10:A+9];
  assign id_regdst_s = id_ctrl[A+7:A+6];

  // Forwarding source for one register: MEM ALU result beats WB data; $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             m_regwr,
    input logic             m_memrd,
    input logic [REG_W-1:0] m_wreg,
    input logic             w_regwr,
    input logic [REG_W-1:0] w_wreg
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0 && m_regwr && !m_memrd && m_wreg == src) begin
      sel = 2'b01;
    end else if (src != '0 && w_regwr && w_wreg == src) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Destination register selection from RegDst.
  always_comb begin
    id_wreg_s = '0;
    case (id_regdst_s)
      2'b00:   id_wreg_s = id_rt;
      2'b01:   id_wreg_s = id_rd;
      2'b10:   id_wreg_s = {REG_W{1'b1}};
      default: id_wreg_s = '0;
    endcase
  end

  assign load_use_s = ex_ctrl[A+5] && (ex_wreg != '0) &&
                      ((ex_wreg == id_rs) || (ex_wreg == id_rt));
  assign jr_haz_s   = (id_pcsrc_s == 2'b10) && (id_rs != '0) &&
                      ((ex_ctrl[A+6] && ex_wreg == id_rs) || (mem_memrd && mem_wreg == id_rs));

  // Hazard resolution (reset > branch > stall > jump) and forwarding selects.
  always_comb begin
    stall_if    = 1'b0;
    flush_ifid  = 1'b0;
    ex_bubble_s = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    id_fwd_rs   = 2'b00;
    if (reset) begin
      ex_bubble_s = 1'b1;
    end else begin
      fwd_a     = fwd_sel(ex_rs, mem_regwr, mem_memrd, mem_wreg, wb_regwr, wb_wreg);
      fwd_b     = fwd_sel(ex_rt, mem_regwr, mem_memrd, mem_wreg, wb_regwr, wb_wreg);
      id_fwd_rs = fwd_sel(id_rs, mem_regwr, mem_memrd, mem_wreg, wb_regwr, wb_wreg);
      if (ex_branch_taken) begin
        // The ID instruction is on the wrong path, so its hazards do not matter.
        flush_ifid  = 1'b1;
        ex_bubble_s = 1'b1;
      end else if (load_use_s || jr_haz_s) begin
        stall_if    = 1'b1;
        ex_bubble_s = 1'b1;
      end else if (id_pcsrc_s != 2'b00) begin
        flush_ifid  = 1'b1;
      end else begin
        ex_bubble_s = 1'b0;
      end
    end
  end

  // Stage registers: ID->EX takes the bundle or a bubble; MEM and WB always advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl      <= '0;
      ex_wreg      <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      mem_regwr    <= 1'b0;
      mem_memrd    <= 1'b0;
      mem_memwr    <= 1'b0;
      mem_memtoreg <= 2'b00;
      mem_wreg     <= '0;
      wb_regwr     <= 1'b0;
      wb_memtoreg  <= 2'b00;
      wb_wreg      <= '0;
    end else begin
      if (ex_bubble_s) begin
        ex_ctrl <= '0;
        ex_wreg <= '0;
        ex_rs   <= '0;
        ex_rt   <= '0;
      end else begin
        ex_ctrl <= {id_ctrl[A+8], id_ctrl[A+5:0]};
        ex_wreg <= id_wreg_s;
        ex_rs   <= id_rs;
        ex_rt   <= id_rt;
      end
      mem_regwr    <= ex_ctrl[A+6];
      mem_memrd    <= ex_ctrl[A+5];
      mem_memwr    <= ex_ctrl[A+4];
      mem_memtoreg <= ex_ctrl[A+3:A+2];
      mem_wreg     <= ex_wreg;
      wb_regwr     <= mem_regwr;
      wb_memtoreg  <= mem_memtoreg;
      wb_wreg      <= mem_wreg;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Randomized bench for pipe_ctrl_hazard: a per-instruction record model of the three
// stages predicts every output each cycle.
module tb_pipe_ctrl_hazard;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_branch_taken;
  logic        stall_if, flush_ifid;
  logic [1:0]  id_fwd_rs;
  logic [10:0] ex_ctrl;
  logic [4:0]  ex_wreg, ex_rs, ex_rt;
  logic [1:0]  fwd_a, fwd_b;
  logic        mem_regwr, mem_memrd, mem_memwr;
  logic [1:0]  mem_memtoreg;
  logic [4:0]  mem_wreg;
  logic        wb_regwr;
  logic [1:0]  wb_memtoreg;
  logic [4:0]  wb_wreg;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_hazard #(.REG_W(5), .ALUOP_W(4)) dut (
    .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_branch_taken(ex_branch_taken), .stall_if(stall_if), .flush_ifid(flush_ifid),
    .id_fwd_rs(id_fwd_rs), .ex_ctrl(ex_ctrl), .ex_wreg(ex_wreg), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_regwr(mem_regwr), .mem_memrd(mem_memrd),
    .mem_memwr(mem_memwr), .mem_memtoreg(mem_memtoreg), .mem_wreg(mem_wreg),
    .wb_regwr(wb_regwr), .wb_memtoreg(wb_memtoreg), .wb_wreg(wb_wreg)
  );

  always #5 clk = ~clk;

  // One in-flight instruction as seen by the control pipeline.
  typedef struct packed {
    logic       regwr;
    logic       memrd;
    logic       memwr;
    logic [1:0] memtoreg;
    logic       as1;
    logic       as2;
    logic [3:0] aluop;
    logic [4:0] wreg;
    logic [4:0] rs;
    logic [4:0] rt;
  } rec_t;

  rec_t st_ex, st_mem, st_wb;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    case ($urandom_range(0, 5))
      0:       r = 5'd0;
      1:       r = 5'd8;
      2:       r = 5'd9;
      3:       r = 5'd31;
      default: r = 5'($urandom_range(0, 31));
    endcase
    return r;
  endfunction

  // Which stage supplies register r to a reader: 1 = MEM ALU result, 2 = WB, 0 = register file.
  function automatic logic [1:0] source_of(input logic [4:0] r, input rec_t m, input rec_t w);
    if (r == 5'd0) return 2'd0;
    if (m.regwr && !m.memrd && m.wreg == r) return 2'd1;
    if (w.regwr && w.wreg == r) return 2'd2;
    return 2'd0;
  endfunction

  initial begin
    rec_t       nxt;
    logic       lu, jr, exp_stall, exp_flush, kill, prev_stall;
    logic [1:0] pcsrc;
    reset = 1'b1;
    id_ctrl = 15'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    ex_branch_taken = 1'b0;
    st_ex = '0; st_mem = '0; st_wb = '0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = (cyc < 2) || ($urandom_range(0, 63) == 0);
      // A stalled instruction stays in ID, as the real IF/ID register would hold it.
      if (!prev_stall) begin
        id_ctrl = 15'($urandom);
        if ($urandom_range(0, 3) != 0) id_ctrl[14:13] = 2'b00;
        id_rs = pick_reg();
        id_rt = pick_reg();
        id_rd = pick_reg();
      end
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      #1;

      pcsrc = id_ctrl[14:13];
      lu = st_ex.memrd && st_ex.wreg != 5'd0 && (st_ex.wreg == id_rs || st_ex.wreg == id_rt);
      jr = pcsrc == 2'b10 && id_rs != 5'd0 &&
           ((st_ex.regwr && st_ex.wreg == id_rs) || (st_mem.memrd && st_mem.wreg == id_rs));
      exp_stall = !reset && !ex_branch_taken && (lu || jr);
      exp_flush = !reset && (ex_branch_taken || (!exp_stall && pcsrc != 2'b00));
      kill      = reset || ex_branch_taken || exp_stall;

      check_eq("stall_if", 32'(stall_if), 32'(exp_stall));
      check_eq("flush_ifid", 32'(flush_ifid), 32'(exp_flush));
      check_eq("fwd_a", 32'(fwd_a), reset ? 32'd0 : 32'(source_of(st_ex.rs, st_mem, st_wb)));
      check_eq("fwd_b", 32'(fwd_b), reset ? 32'd0 : 32'(source_of(st_ex.rt, st_mem, st_wb)));
      if (!jr) check_eq("id_fwd_rs", 32'(id_fwd_rs), reset ? 32'd0 : 32'(source_of(id_rs, st_mem, st_wb)));
      check_eq("ex_ctrl", 32'(ex_ctrl),
               32'({st_ex.regwr, st_ex.memrd, st_ex.memwr, st_ex.memtoreg, st_ex.as1, st_ex.as2, st_ex.aluop}));
      check_eq("ex_wreg", 32'(ex_wreg), 32'(st_ex.wreg));
      check_eq("ex_rs", 32'(ex_rs), 32'(st_ex.rs));
      check_eq("ex_rt", 32'(ex_rt), 32'(st_ex.rt));
      check_eq("mem_bits", 32'({mem_regwr, mem_memrd, mem_memwr, mem_memtoreg}),
               32'({st_mem.regwr, st_mem.memrd, st_mem.memwr, st_mem.memtoreg}));
      check_eq("mem_wreg", 32'(mem_wreg), 32'(st_mem.wreg));
      check_eq("wb_bits", 32'({wb_regwr, wb_memtoreg}), 32'({st_wb.regwr, st_wb.memtoreg}));
      check_eq("wb_wreg", 32'(wb_wreg), 32'(st_wb.wreg));

      // Instruction that enters EX at the coming edge.
      nxt = '0;
      if (!kill) begin
        nxt.regwr    = id_ctrl[12];
        nxt.memrd    = id_ctrl[9];
        nxt.memwr    = id_ctrl[8];
        nxt.memtoreg = id_ctrl[7:6];
        nxt.as1      = id_ctrl[5];
        nxt.as2      = id_ctrl[4];
        nxt.aluop    = id_ctrl[3:0];
        nxt.rs       = id_rs;
        nxt.rt       = id_rt;
        case (id_ctrl[11:10])
          2'b00:   nxt.wreg = id_rt;
          2'b01:   nxt.wreg = id_rd;
          2'b10:   nxt.wreg = 5'd31;
          default: nxt.wreg = 5'd0;
        endcase
      end
      if (reset) begin
        st_wb = '0; st_mem = '0; st_ex = '0;
      end else begin
        st_wb = st_mem; st_mem = st_ex; st_ex = nxt;
      end
      prev_stall = exp_stall;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
